// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one adder iterated WIDTH times, start/ready/done handshake.
// Define SEQ_MULT_SIGNED_EN for two's complement operands and product (sign-magnitude internally).
module seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    result;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg;

    // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is still correct read as unsigned.
    assign a_mag  = a[WIDTH-1] ? WIDTH'(-a) : a;
    assign b_mag  = b[WIDTH-1] ? WIDTH'(-b) : b;
    assign result = neg ? PW'(-acc_sum) : acc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg <= 1'b0;
        end else if (state == IDLE && start) begin
            neg <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign result = acc_sum;
`endif

    assign acc_sum = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= PW'(a_mag);
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) p <= result;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: WIDTH=8 directed/random instance plus WIDTH=3 exhaustive instance.
// Reference products come from plain integer arithmetic (signed when SEQ_MULT_SIGNED_EN is defined).
module tb_seq_mult;
    localparam int W8 = 8;
    localparam int W3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, ready8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        start3, ready3, busy3, done3;
    logic [2:0]  a3, b3;
    logic [5:0]  p3;

    seq_mult #(.WIDTH(W8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .p(p8)
    );

    seq_mult #(.WIDTH(W3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
        .ready(ready3), .busy(busy3), .done(done3), .p(p3)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] exp8_q[$];
    int          lat8_q[$];
    logic [5:0]  exp3_q[$];
    int          lat3_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
`ifdef SEQ_MULT_SIGNED_EN
        int sx = int'($signed(x));
        int sy = int'($signed(y));
`else
        int sx = int'(x);
        int sy = int'(y);
`endif
        return 16'(sx * sy);
    endfunction

    function automatic logic [5:0] model3(input logic [2:0] x, input logic [2:0] y);
`ifdef SEQ_MULT_SIGNED_EN
        int sx = int'($signed(x));
        int sy = int'($signed(y));
`else
        int sx = int'(x);
        int sy = int'(y);
`endif
        return 6'(sx * sy);
    endfunction

    // Monitor for the WIDTH=8 instance
    logic [15:0] last_p8 = '0;
    bit          chk_rdy8 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            last_p8  = '0;
            chk_rdy8 = 1'b0;
        end else begin
            if (chk_rdy8) begin
                check("ready8_after_done", ready8, 1'b1);
                chk_rdy8 = 1'b0;
            end
            if (done8) begin
                if (exp8_q.size() == 0) begin
                    fail_now("done8_unexpected");
                end else begin
                    check("p8", p8, exp8_q.pop_front());
                    check("lat8", cyc, lat8_q.pop_front());
                end
                last_p8  = p8;
                chk_rdy8 = 1'b1;
            end else begin
                check("p8_hold", p8, last_p8);
            end
        end
    end

    // Monitor for the WIDTH=3 instance
    logic [5:0] last_p3 = '0;
    bit         chk_rdy3 = 1'b0;
    int         last_done3 = -1;
    always @(negedge clk) begin
        if (!rst_n) begin
            last_p3  = '0;
            chk_rdy3 = 1'b0;
        end else begin
            if (chk_rdy3) begin
                check("ready3_after_done", ready3, 1'b1);
                chk_rdy3 = 1'b0;
            end
            if (done3) begin
                if (exp3_q.size() == 0) begin
                    fail_now("done3_unexpected");
                end else begin
                    check("p3", p3, exp3_q.pop_front());
                    check("lat3", cyc, lat3_q.pop_front());
                end
                if (last_done3 >= 0) check("gap3", cyc - last_done3, W3 + 2);
                last_done3 = cyc;
                last_p3    = p3;
                chk_rdy3   = 1'b1;
            end else begin
                check("p3_hold", p3, last_p3);
            end
        end
    end

    // Called at a negedge; waits for ready, then pulses start for one cycle.
    task automatic issue8(input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        while (ready8 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("issue8_ready_timeout");
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        exp8_q.push_back(model8(x, y));
        lat8_q.push_back(cyc + 1 + W8);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (exp8_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("wait_idle8_timeout");
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start8 = 1'b0;
        start3 = 1'b0;
        a8 = '0; b8 = '0;
        a3 = '0; b3 = '0;
        repeat (3) @(negedge clk);
        check("rst_ready8", ready8, 1'b1);
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        check("rst_p8", p8, 16'h0000);
        check("rst_ready3", ready3, 1'b1);
        check("rst_p3", p3, 6'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready8", ready8, 1'b1);
        check("idle_busy8", busy8, 1'b0);
        check("idle_p8", p8, 16'h0000);

        issue8(8'd255, 8'd255);
        wait_idle8();
        issue8(8'd0, 8'd200);
        wait_idle8();

        // Busy rejection: a second request inside RUN must produce nothing
        issue8(8'd13, 8'd11);
        check("busy8_in_run", busy8, 1'b1);
        a8 = 8'd99;
        b8 = 8'd99;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle8();
        repeat (12) @(negedge clk);

        // Abort mid-operation
        issue8(8'd100, 8'd100);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready8", ready8, 1'b1);
        check("abort_busy8", busy8, 1'b0);
        check("abort_done8", done8, 1'b0);
        check("abort_p8", p8, 16'h0000);
        exp8_q.delete();
        lat8_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue8(8'd3, 8'd4);
        wait_idle8();

        issue8(8'hFD, 8'd5);
        issue8(8'h80, 8'h80);
        issue8(8'h80, 8'h7F);
        issue8(8'h7F, 8'h7F);
        wait_idle8();

        for (int i = 0; i < 30; i++) begin
            issue8(8'($urandom), 8'($urandom));
        end
        wait_idle8();

        // Exhaustive WIDTH=3 with start held high
        for (int i = 0; i < 64; i++) begin
            logic [5:0] ab;
            int n;
            ab = 6'(i);
            n = 0;
            while (ready3 !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) fail_now("issue3_ready_timeout");
            a3 = ab[5:3];
            b3 = ab[2:0];
            start3 = 1'b1;
            exp3_q.push_back(model3(ab[5:3], ab[2:0]));
            lat3_q.push_back(cyc + 1 + W3);
            @(negedge clk);
        end
        start3 = 1'b0;
        begin
            int n = 0;
            while (exp3_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) fail_now("wait_idle3_timeout");
        end
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised sequential shift-add multiplier. Generalises the combinational 3-bit array multiplier to any WIDTH.
- Uses one adder over WIDTH cycles instead of WIDTH^2 AND gates and a ripple chain.
- Uses a start/ready/done handshake, so arithmetic datapaths can share one multiplier across several operations.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits

Ports:
clk    input   1          rising-edge clock
rst_n  input   1          asynchronous active-low reset
start  input   1          request; accepted only on a rising edge where ready=1
a      input   WIDTH      multiplicand; sampled on the accept edge
b      input   WIDTH      multiplier; sampled on the accept edge
ready  output  1          1 in IDLE only; block can accept start
busy   output  1          1 in RUN and DONE
done   output  1          single-cycle pulse; p is valid in that cycle
p      output  2*WIDTH    product; holds its last result until the next done

Behaviour:
- Reset: rst_n=0 asynchronously forces state=IDLE, ready=1, busy=0, done=0, p=0, bit counter=0, internal registers=0.
- Reset mid-operation aborts the multiply. No done is produced for the aborted operation.
- State IDLE:
  - ready=1.
  - On an edge with start=1: latch a into mcand (zero-extended to 2*WIDTH) and b into mplier, clear acc, set cnt=0, go to RUN.
- State RUN:
  - Each edge: if mplier[0]=1 then acc <= acc + mcand (2*WIDTH-bit add, no overflow possible).
  - Same edge: mcand <= mcand<<1, mplier <= mplier>>1, cnt <= cnt+1.
  - After the edge where cnt=WIDTH-1 is processed: p <= final acc, go to DONE.
- State DONE:
  - done=1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency:
  - Accept edge k; RUN occupies edges k+1..k+WIDTH; done=1 in the cycle following edge k+WIDTH.
  - ready returns to 1 after edge k+WIDTH+1.
  - Throughput is one product per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored; no queuing. a/b changes during RUN have no effect.
- start held high continuously: a new operation is accepted on each IDLE edge, so back-to-back operations run with one IDLE cycle between them.
- p changes only on the edge entering DONE; it is stable at all other times.
- Result is exact for all inputs. Unsigned range is 0 .. (2^WIDTH-1)^2.
- cnt width is clog2(WIDTH)+1 bits; cnt does not wrap within an operation.
- No early termination on zero operands; latency is data-independent.

Optional Feature:
SEQ_MULT_SIGNED_EN
- Defined:
  - a, b and p are two's complement.
  - On accept, latch the magnitudes |a| and |b| and neg = a[WIDTH-1]^b[WIDTH-1].
  - RUN operates on the magnitudes. On the edge entering DONE, p <= neg ? -acc : acc.
  - The magnitude of -2^(WIDTH-1) fits unsigned in WIDTH bits, so every input pair is exact. For WIDTH=8, -128*-128 = +16384.
  - Latency is unchanged.
- Undefined:
  - Purely unsigned operation as described in Behaviour; no sign logic is synthesised.

Test Plan:
- Reset, then idle: rst_n low 3 cycles then high -> ready=1, busy=0, done=0, p=0x0000.
- Max operands, WIDTH=8: a=255, b=255 with start one cycle -> done exactly 8 cycles after the accept edge, p=0xFE01; ready=1 one cycle after done.
- Zero and busy rejection:
  - a=0, b=200 -> p=0.
  - Then a=13, b=11 accepted; pulse start with a=99, b=99 during RUN -> single done, p=143; the second request is ignored.
- Reset mid-operation: accept a=100, b=100; assert rst_n low at RUN cycle 4 -> no done; p=0, ready=1 immediately. A following a=3, b=4 gives p=12.
- Exhaustive WIDTH=3: all 64 {a,b} pairs with start held high -> each done's p equals a*b; at least one IDLE cycle between dones.
- Signed, with SEQ_MULT_SIGNED_EN and WIDTH=8:
  - a=-3 (0xFD), b=5 -> p=0xFFF1.
  - a=-128, b=-128 -> p=0x4000.
  - a=-128, b=127 -> p=0xC080.
